// File: rtl/gpu_pkg.sv
// Shared GPU core encodings: scheduler stages and LSU per-thread states.
package gpu_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'd0,
        CORE_FETCH   = 3'd1,
        CORE_DECODE  = 3'd2,
        CORE_REQUEST = 3'd3,
        CORE_WAIT    = 3'd4,
        CORE_EXECUTE = 3'd5,
        CORE_UPDATE  = 3'd6,
        CORE_DONE    = 3'd7
    } core_state_e;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'd0,
        LSU_REQUESTING = 2'd1,
        LSU_WAITING    = 2'd2,
        LSU_DONE       = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_bank_if.sv
// Consumer-side read/write handshake between the LSU bank and the memory controller.
interface lsu_bank_if #(
    parameter int THREADS    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [THREADS-1:0]                 read_valid;
    logic [THREADS-1:0][ADDR_WIDTH-1:0] read_addr;
    logic [THREADS-1:0]                 read_ready;
    logic [THREADS-1:0][DATA_WIDTH-1:0] read_data;
    logic [THREADS-1:0]                 write_valid;
    logic [THREADS-1:0][ADDR_WIDTH-1:0] write_addr;
    logic [THREADS-1:0][DATA_WIDTH-1:0] write_data;
    logic [THREADS-1:0]                 write_ready;

    // LSU side issues requests
    modport master (
        output read_valid, read_addr, write_valid, write_addr, write_data,
        input  read_ready, read_data, write_ready
    );

    // Memory controller side services them
    modport slave (
        input  read_valid, read_addr, write_valid, write_addr, write_data,
        output read_ready, read_data, write_ready
    );
endinterface

// File: rtl/lsu_thread.sv
// Single-thread LSU: IDLE -> REQUESTING -> WAITING -> DONE, plus request/result registers.
module lsu_thread
    import gpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  thread_enable,
    input  core_state_e           core_state,
    input  logic                  mem_read_enable,
    input  logic                  mem_write_enable,
    input  logic [DATA_WIDTH-1:0] rs,
    input  logic [DATA_WIDTH-1:0] rt,
    output logic [1:0]            lsu_state,
    output logic [DATA_WIDTH-1:0] lsu_out,
    output logic                  read_valid,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic                  read_ready,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  write_valid,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_ready
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Valid is raised on entry to REQUESTING so it is visible during that cycle;
    // ready is only honoured in WAITING, and only for the direction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            lsu_state   <= S_IDLE;
            lsu_out     <= '0;
            read_valid  <= 1'b0;
            read_addr   <= '0;
            write_valid <= 1'b0;
            write_addr  <= '0;
            write_data  <= '0;
        end else if (enable) begin
            case (lsu_state)
                S_IDLE: begin
                    if (thread_enable && core_state == CORE_REQUEST &&
                        (mem_read_enable || mem_write_enable)) begin
                        lsu_state <= S_REQ;
                        // Both enables set is an illegal decode: treat it as a load.
                        if (mem_read_enable) begin
                            read_valid <= 1'b1;
                            read_addr  <= rs[ADDR_WIDTH-1:0];
                        end else begin
                            write_valid <= 1'b1;
                            write_addr  <= rs[ADDR_WIDTH-1:0];
                            write_data  <= rt;
                        end
                    end
                end
                S_REQ: lsu_state <= S_WAIT;
                S_WAIT: begin
                    if (read_valid && read_ready) begin
                        lsu_out    <= read_data;
                        read_valid <= 1'b0;
                        lsu_state  <= S_DONE;
                    end else if (write_valid && write_ready) begin
                        write_valid <= 1'b0;
                        lsu_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (core_state == CORE_UPDATE) lsu_state <= S_IDLE;
                end
                default: lsu_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/lsu_bank.sv
// Per-core LSU bank: one independent lsu_thread per thread slot plus the all_done reduction.
module lsu_bank
    import gpu_pkg::*;
#(
    parameter int THREADS    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic [THREADS-1:0]                thread_enable,
    input  core_state_e                       core_state,
    input  logic                              mem_read_enable,
    input  logic                              mem_write_enable,
    input  logic [THREADS-1:0][DATA_WIDTH-1:0] rs,
    input  logic [THREADS-1:0][DATA_WIDTH-1:0] rt,
    output logic [THREADS-1:0][1:0]           lsu_state,
    output logic [THREADS-1:0][DATA_WIDTH-1:0] lsu_out,
    output logic                              all_done,
    lsu_bank_if.master                        bus
);
    logic [THREADS-1:0]                 rd_valid;
    logic [THREADS-1:0][ADDR_WIDTH-1:0] rd_addr;
    logic [THREADS-1:0]                 wr_valid;
    logic [THREADS-1:0][ADDR_WIDTH-1:0] wr_addr;
    logic [THREADS-1:0][DATA_WIDTH-1:0] wr_data;

    assign bus.read_valid  = rd_valid;
    assign bus.read_addr   = rd_addr;
    assign bus.write_valid = wr_valid;
    assign bus.write_addr  = wr_addr;
    assign bus.write_data  = wr_data;

    for (genvar t = 0; t < THREADS; t++) begin : g_thread
        lsu_thread #(
            .ADDR_WIDTH(ADDR_WIDTH),
            .DATA_WIDTH(DATA_WIDTH)
        ) u_thread (
            .clk              (clk),
            .rst              (rst),
            .enable           (enable),
            .thread_enable    (thread_enable[t]),
            .core_state       (core_state),
            .mem_read_enable  (mem_read_enable),
            .mem_write_enable (mem_write_enable),
            .rs               (rs[t]),
            .rt               (rt[t]),
            .lsu_state        (lsu_state[t]),
            .lsu_out          (lsu_out[t]),
            .read_valid       (rd_valid[t]),
            .read_addr        (rd_addr[t]),
            .read_ready       (bus.read_ready[t]),
            .read_data        (bus.read_data[t]),
            .write_valid      (wr_valid[t]),
            .write_addr       (wr_addr[t]),
            .write_data       (wr_data[t]),
            .write_ready      (bus.write_ready[t])
        );
    end

    // Masked-off threads never block completion; an empty mask reads as done.
    always_comb begin
        all_done = 1'b1;
        for (int t = 0; t < THREADS; t++) begin
            if (thread_enable[t] && lsu_state[t] != LSU_DONE) all_done = 1'b0;
        end
    end
endmodule

// File: tb/tb_lsu_bank.sv
// Scenario bench for lsu_bank with a transaction-level expectation model.
module tb_lsu_bank;
    import gpu_pkg::*;

    localparam int T  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic [T-1:0]         thread_enable;
    core_state_e          core_state;
    logic                 mem_read_enable;
    logic                 mem_write_enable;
    logic [T-1:0][DW-1:0] rs;
    logic [T-1:0][DW-1:0] rt;
    logic [T-1:0][1:0]    lsu_state;
    logic [T-1:0][DW-1:0] lsu_out;
    logic                 all_done;

    lsu_bank_if #(.THREADS(T), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    lsu_bank #(.THREADS(T), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .thread_enable    (thread_enable),
        .core_state       (core_state),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .rs               (rs),
        .rt               (rt),
        .lsu_state        (lsu_state),
        .lsu_out          (lsu_out),
        .all_done         (all_done),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    // Last completed load value per thread (0 after reset)
    logic [DW-1:0] exp_out [T];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        core_state       = CORE_WAIT;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        bus.read_ready   = '0;
        bus.write_ready  = '0;
    endtask

    // Present a decoded op in the REQUEST stage for one cycle
    task automatic issue(input logic r, input logic w);
        core_state       = CORE_REQUEST;
        mem_read_enable  = r;
        mem_write_enable = w;
        tick();
        quiet();
    endtask

    task automatic update();
        core_state = CORE_UPDATE;
        tick();
        quiet();
    endtask

    task automatic test_reset();
        logic [DW-1:0] d;
        rst = 1'b1; enable = 1'b1; thread_enable = 4'b0001; quiet();
        rs = '0; rt = '0; bus.read_data = '0;
        tick(); tick();
        if (lsu_state !== '0) begin n_fail++; $display("FAIL reset_state act=%h exp=0", lsu_state); end n_tests++;
        if (lsu_out !== '0) begin n_fail++; $display("FAIL reset_out act=%h exp=0", lsu_out); end n_tests++;
        if ({bus.read_valid, bus.write_valid} !== '0) begin n_fail++; $display("FAIL reset_valid act=%h exp=0", {bus.read_valid, bus.write_valid}); end n_tests++;
        if ({bus.read_addr, bus.write_addr, bus.write_data} !== '0) begin n_fail++; $display("FAIL reset_bus act=%h exp=0", {bus.read_addr, bus.write_addr, bus.write_data}); end n_tests++;
        if (all_done !== 1'b0) begin n_fail++; $display("FAIL reset_all_done act=%b exp=0", all_done); end n_tests++;
        for (int t = 0; t < T; t++) exp_out[t] = '0;
        // Reset in the middle of a load
        rst = 1'b0;
        rs[0] = DW'($urandom);
        issue(1'b1, 1'b0);
        tick();
        if (lsu_state[0] !== 2'd2 || bus.read_valid[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_pre act=%h/%b exp=2/1", lsu_state[0], bus.read_valid[0]); end n_tests++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if (lsu_state !== '0 || bus.read_valid !== '0 || bus.read_addr !== '0) begin n_fail++; $display("FAIL midrst_clear act=%h/%h/%h exp=0", lsu_state, bus.read_valid, bus.read_addr); end n_tests++;
        tick();
        d = DW'($urandom_range(1, 255));
        bus.read_data[0] = d; bus.read_ready[0] = 1'b1;
        tick(); quiet();
        if (lsu_out[0] !== 8'h00 || lsu_state[0] !== 2'd0) begin n_fail++; $display("FAIL late_ready act=%h/%h exp=00/0", lsu_out[0], lsu_state[0]); end n_tests++;
    endtask

    task automatic test_single_load();
        thread_enable = 4'b0001;
        rs[0] = 8'h2A;
        issue(1'b1, 1'b0);
        if (bus.read_valid !== 4'b0001 || bus.read_addr[0] !== 8'h2A) begin n_fail++; $display("FAIL load_req act=%h/%h exp=1/2a", bus.read_valid, bus.read_addr[0]); end n_tests++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (lsu_state[0] !== 2'd2 || bus.read_valid[0] !== 1'b1 || bus.read_addr[0] !== 8'h2A) begin n_fail++; $display("FAIL load_hold act=%h/%b/%h exp=2/1/2a", lsu_state[0], bus.read_valid[0], bus.read_addr[0]); end n_tests++;
        end
        bus.read_data[0] = 8'h5C; bus.read_ready[0] = 1'b1;
        tick(); quiet();
        exp_out[0] = 8'h5C;
        if (lsu_out[0] !== 8'h5C || lsu_state[0] !== 2'd3 || all_done !== 1'b1 || bus.read_valid[0] !== 1'b0) begin n_fail++; $display("FAIL load_done act=%h/%h/%b/%b exp=5c/3/1/0", lsu_out[0], lsu_state[0], all_done, bus.read_valid[0]); end n_tests++;
        update();
        if (lsu_state[0] !== 2'd0 || lsu_out[0] !== 8'h5C || all_done !== 1'b0) begin n_fail++; $display("FAIL load_update act=%h/%h/%b exp=0/5c/0", lsu_state[0], lsu_out[0], all_done); end n_tests++;
    endtask

    task automatic test_store_all();
        int           ord [4] = '{2, 0, 3, 1};
        logic [T-1:0] done_m = '0;
        thread_enable = 4'b1111;
        for (int t = 0; t < T; t++) begin rs[t] = DW'(8'h10 + t); rt[t] = DW'(8'hA0 + t); end
        issue(1'b0, 1'b1);
        if (bus.write_valid !== 4'hF || bus.read_valid !== 4'h0) begin n_fail++; $display("FAIL store_req act=%h/%h exp=f/0", bus.write_valid, bus.read_valid); end n_tests++;
        tick();
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(1, 3)) tick();
            bus.write_ready[ord[k]] = 1'b1;
            tick(); quiet();
            done_m[ord[k]] = 1'b1;
            for (int t = 0; t < T; t++) begin
                if (lsu_state[t] !== (done_m[t] ? 2'd3 : 2'd2) || bus.write_valid[t] !== !done_m[t]) begin n_fail++; $display("FAIL store_state t%0d act=%h/%b exp_done=%b", t, lsu_state[t], bus.write_valid[t], done_m[t]); end n_tests++;
                if (!done_m[t] && (bus.write_addr[t] !== AW'(8'h10 + t) || bus.write_data[t] !== DW'(8'hA0 + t))) begin n_fail++; $display("FAIL store_hold t%0d act=%h/%h", t, bus.write_addr[t], bus.write_data[t]); end n_tests++;
            end
            if (all_done !== (done_m == 4'hF)) begin n_fail++; $display("FAIL store_all_done act=%b exp=%b", all_done, done_m == 4'hF); end n_tests++;
        end
        update();
        if (lsu_state !== '0 || lsu_out[0] !== exp_out[0]) begin n_fail++; $display("FAIL store_update act=%h/%h", lsu_state, lsu_out[0]); end n_tests++;
    endtask

    task automatic test_mask();
        logic [DW-1:0] d0, d2;
        thread_enable = 4'b0101;
        for (int t = 0; t < T; t++) rs[t] = DW'($urandom);
        issue(1'b1, 1'b0);
        if (bus.read_valid !== 4'b0101 || bus.read_addr[0] !== rs[0] || bus.read_addr[2] !== rs[2]) begin n_fail++; $display("FAIL mask_req act=%h exp=5", bus.read_valid); end n_tests++;
        tick();
        d0 = DW'($urandom); d2 = DW'($urandom);
        bus.read_data[0] = d0; bus.read_ready[0] = 1'b1;
        tick(); quiet();
        if (all_done !== 1'b0 || lsu_state[0] !== 2'd3) begin n_fail++; $display("FAIL mask_partial act=%b/%h exp=0/3", all_done, lsu_state[0]); end n_tests++;
        bus.read_data[2] = d2; bus.read_ready[2] = 1'b1;
        tick(); quiet();
        exp_out[0] = d0; exp_out[2] = d2;
        if (all_done !== 1'b1 || lsu_out[0] !== d0 || lsu_out[2] !== d2 || lsu_state[1] !== 2'd0 || lsu_state[3] !== 2'd0) begin n_fail++; $display("FAIL mask_done act=%b/%h/%h/%h", all_done, lsu_out[0], lsu_out[2], lsu_state); end n_tests++;
        update();
    endtask

    task automatic test_spurious();
        logic [DW-1:0] d;
        thread_enable = 4'b0001;
        rs[0] = DW'($urandom);
        core_state = CORE_REQUEST; mem_read_enable = 1'b1;
        tick(); quiet();
        // Ready coinciding with the first valid cycle does not count
        bus.read_data[0] = DW'($urandom); bus.read_ready[0] = 1'b1;
        tick(); quiet();
        if (lsu_state[0] !== 2'd2 || lsu_out[0] !== exp_out[0]) begin n_fail++; $display("FAIL early_ready act=%h/%h exp=2/%h", lsu_state[0], lsu_out[0], exp_out[0]); end n_tests++;
        bus.write_ready[0] = 1'b1;
        tick(); quiet();
        if (lsu_state[0] !== 2'd2 || bus.read_valid[0] !== 1'b1) begin n_fail++; $display("FAIL cross_ready act=%h/%b exp=2/1", lsu_state[0], bus.read_valid[0]); end n_tests++;
        bus.read_data[1] = DW'($urandom); bus.read_ready[1] = 1'b1;
        tick(); quiet();
        if (lsu_state[1] !== 2'd0 || lsu_out[1] !== exp_out[1]) begin n_fail++; $display("FAIL idle_ready act=%h/%h exp=0/%h", lsu_state[1], lsu_out[1], exp_out[1]); end n_tests++;
        d = DW'($urandom);
        bus.read_data[0] = d; bus.read_ready[0] = 1'b1;
        tick(); quiet();
        exp_out[0] = d;
        if (lsu_state[0] !== 2'd3 || lsu_out[0] !== d) begin n_fail++; $display("FAIL spur_finish act=%h/%h exp=3/%h", lsu_state[0], lsu_out[0], d); end n_tests++;
        update();
    endtask

    task automatic test_freeze();
        thread_enable = 4'b0001;
        rs[0] = DW'($urandom);
        issue(1'b1, 1'b0);
        tick();
        enable = 1'b0;
        bus.read_data[0] = 8'h33; bus.read_ready[0] = 1'b1;
        tick(); quiet();
        tick();
        if (lsu_state[0] !== 2'd2 || bus.read_valid[0] !== 1'b1 || lsu_out[0] !== exp_out[0]) begin n_fail++; $display("FAIL frozen act=%h/%b/%h exp=2/1/%h", lsu_state[0], bus.read_valid[0], lsu_out[0], exp_out[0]); end n_tests++;
        enable = 1'b1;
        tick();
        if (lsu_state[0] !== 2'd2) begin n_fail++; $display("FAIL thaw act=%h exp=2", lsu_state[0]); end n_tests++;
        bus.read_data[0] = 8'h77; bus.read_ready[0] = 1'b1;
        tick(); quiet();
        exp_out[0] = 8'h77;
        if (lsu_state[0] !== 2'd3 || lsu_out[0] !== 8'h77) begin n_fail++; $display("FAIL freeze_done act=%h/%h exp=3/77", lsu_state[0], lsu_out[0]); end n_tests++;
        update();
    endtask

    task automatic test_back_to_back();
        int            dly [T];
        int            op;
        logic          r, w, exp_ad;
        logic [DW-1:0] d;
        for (int it = 0; it < 20; it++) begin
            thread_enable = T'($urandom_range(1, 15));
            op = $urandom_range(0, 2);
            r = (op != 1); w = (op != 0);
            for (int t = 0; t < T; t++) begin rs[t] = DW'($urandom); rt[t] = DW'($urandom); dly[t] = $urandom_range(0, 4); end
            issue(r, w);
            if (bus.read_valid !== (r ? thread_enable : 4'h0) || bus.write_valid !== (r ? 4'h0 : thread_enable)) begin n_fail++; $display("FAIL rnd_req it%0d act=%h/%h te=%h op=%0d", it, bus.read_valid, bus.write_valid, thread_enable, op); end n_tests++;
            tick();
            for (int c = 0; c < 6; c++) begin
                for (int t = 0; t < T; t++) begin
                    if (thread_enable[t] && dly[t] == c) begin
                        d = DW'($urandom);
                        if (r) begin bus.read_data[t] = d; bus.read_ready[t] = 1'b1; exp_out[t] = d; end
                        else bus.write_ready[t] = 1'b1;
                    end
                end
                tick(); quiet();
                exp_ad = 1'b1;
                for (int t = 0; t < T; t++) begin
                    if (thread_enable[t]) begin
                        if (dly[t] > c) exp_ad = 1'b0;
                        if (lsu_state[t] !== (dly[t] <= c ? 2'd3 : 2'd2)) begin n_fail++; $display("FAIL rnd_state it%0d c%0d t%0d act=%h dly=%0d", it, c, t, lsu_state[t], dly[t]); end n_tests++;
                    end
                end
                if (all_done !== exp_ad) begin n_fail++; $display("FAIL rnd_all_done it%0d c%0d act=%b exp=%b", it, c, all_done, exp_ad); end n_tests++;
            end
            for (int t = 0; t < T; t++) begin
                if (lsu_out[t] !== exp_out[t]) begin n_fail++; $display("FAIL rnd_out it%0d t%0d act=%h exp=%h", it, t, lsu_out[t], exp_out[t]); end n_tests++;
            end
            update();
            if (lsu_state !== '0) begin n_fail++; $display("FAIL rnd_update it%0d act=%h exp=0", it, lsu_state); end n_tests++;
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_store_all();
        test_mask();
        test_spurious();
        test_freeze();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu_bank.md
Name: lsu_bank

Overview:
- Per-core load/store unit bank: one independent LSU FSM per thread slot.
- Turns decoded LDR/STR micro-ops into consumer-side read/write handshakes on the memory controller.
- Sits directly upstream of the memory controller. Its per-thread valid/addr/data outputs drive one controller consumer slot each; it consumes that slot's ready pulse and read data.
- Reports per-thread status and result to the core scheduler and register file.

Parameters:
- THREADS, 4: thread slots (consumer slots) per core
- ADDR_WIDTH, 8: memory address width
- DATA_WIDTH, 8: data width

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  block enable; when 0, all FSMs hold state
- thread_enable  in  THREADS  active-thread mask
- core_state  in  3  scheduler stage (encoding in gpu_pkg)
- mem_read_enable  in  1  decoded LDR
- mem_write_enable  in  1  decoded STR
- rs  in  THREADS*DATA_WIDTH  per-thread address operand (low ADDR_WIDTH bits used)
- rt  in  THREADS*DATA_WIDTH  per-thread store data
- lsu_state  out  THREADS*2  per-thread FSM state
- lsu_out  out  THREADS*DATA_WIDTH  per-thread load result
- all_done  out  1  every enabled thread in DONE
- read_valid  out  THREADS  to controller consumer_read_valid
- read_addr  out  THREADS*ADDR_WIDTH
- read_ready  in  THREADS  from controller consumer_read_ready (1-cycle pulse)
- read_data  in  THREADS*DATA_WIDTH
- write_valid  out  THREADS
- write_addr  out  THREADS*ADDR_WIDTH
- write_data  out  THREADS*DATA_WIDTH
- write_ready  in  THREADS  1-cycle completion pulse

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous, active-high.
- On reset, every output is 0: lsu_state=IDLE, lsu_out=0, read_valid=0, write_valid=0, addresses and data 0, all_done=0.
- Per-thread FSM states: IDLE=0, REQUESTING=1, WAITING=2, DONE=3.
- IDLE -> REQUESTING when enable & thread_enable[t] & core_state==REQUEST & (mem_read_enable | mem_write_enable).
- mem_read_enable and mem_write_enable both high is an illegal decode. Read wins, and no write is issued.
- REQUESTING (1 cycle):
  - Read: assert read_valid[t], read_addr[t]=rs[t][ADDR_WIDTH-1:0].
  - Write: assert write_valid[t], addr likewise, write_data[t]=rt[t].
  - Next state is WAITING.
- WAITING:
  - valid stays asserted and addr/data stay stable until the matching ready pulse.
  - On read_ready[t]: lsu_out[t]<=read_data[t], read_valid[t]<=0, go to DONE.
  - On write_ready[t]: write_valid[t]<=0, go to DONE.
  - A ready pulse for the opposite direction is ignored.
  - A ready pulse in any state other than WAITING is ignored, including one in the same cycle valid first rises.
- Minimum latency: request stage to DONE is 3 cycles (IDLE->REQ->WAIT, ready on the WAIT cycle, DONE next cycle).
- DONE -> IDLE when core_state==UPDATE. lsu_out holds its value until the next load completes.
- all_done is combinational: AND over t of (!thread_enable[t] | lsu_state[t]==DONE). It is 1 when thread_enable==0.
- Threads are fully independent. Ready pulses to different threads in the same cycle are all accepted.
- enable=0 freezes FSM state and outputs, including valids. A ready pulse arriving while frozen is dropped, and the thread stays in WAITING until the next pulse.
- Reset mid-transaction returns to IDLE immediately and drops valids the following edge. A late ready pulse after reset is ignored (thread is IDLE).
- Widths: rs truncated to ADDR_WIDTH; no arithmetic; no wrap concerns.

Decomposition:
- gpu_pkg holds:
  - core_state_e: IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7
  - lsu_state_e: 2-bit encoding above
- One sub-module, lsu_thread: single-thread FSM plus output registers. lsu_bank generates THREADS instances and the all_done reduction.

Test Plan:
1. Reset while thread 0 is WAITING with read_valid=1 -> next cycle all outputs 0, lsu_state=0. A read_ready pulse two cycles later leaves lsu_out=0.
2. Single load: thread_enable=4'b0001, rs[0]=0x2A, LDR at REQUEST.
   - read_valid[0]=1, read_addr=0x2A the next cycle.
   - Ready pulse 5 cycles later with data 0x5C -> lsu_out[0]=0x5C, state DONE, all_done=1.
   - UPDATE -> IDLE.
3. Store on all 4 threads: rs=0x10..0x13, rt=0xA0..0xA3.
   - write_ready pulses arrive in order 2,0,3,1 on different cycles.
   - all_done rises only the cycle after the last pulse.
   - Each addr/data pair is held stable until its own pulse.
4. Mask: thread_enable=4'b0101 with an LDR -> only threads 0 and 2 assert read_valid. all_done requires only those two.
5. Spurious and cross pulses: write_ready[0] while thread 0 WAITs on a read -> ignored, still WAITING. A read_ready to an IDLE thread -> no state change.
6. enable=0 during WAITING, with the ready pulse arriving while frozen -> pulse dropped, thread remains WAITING. After re-enable, a second pulse (data 0x77) -> DONE, lsu_out=0x77.
